// File: rtl/alu_pkg.sv
// Shared ALU-control op codes and FSM state type for the multicycle ALU.
// The ALU control decoder imports the same codes.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the ALU controller and the multicycle ALU.
interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [2:0]       gin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, gin, a, b,
    input  result, zero, busy, done
  );

  modport slave (
    input  start, gin, a, b,
    output result, zero, busy, done
  );

endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// product is the accumulator value after the current step; last flags the final step.
module mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             last
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CntW-1:0]  count_q;

  always_comb begin
    product = acc_q + (mplier_q[0] ? mcand_q : '0);
    last    = (count_q == CntW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      count_q  <= CntW'(WIDTH);
    end else if (step) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// ALU with single-cycle logic/arith ops and a WIDTH-cycle iterative multiply.
// Holds the IDLE/MUL FSM, the single-cycle datapath and the result registers.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_alu_if.slave   bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] mul_product;
  logic             mul_last;
  logic             mul_load;
  logic             mul_step;

  // Op 101 and the mul code fall to default: 101 completes here with a zero result.
  always_comb begin
    alu_out = '0;
    case (bus.gin)
      ALU_AND: alu_out = bus.a & bus.b;
      ALU_OR:  alu_out = bus.a | bus.b;
      ALU_ADD: alu_out = bus.a + bus.b;
      ALU_SUB: alu_out = bus.a - bus.b;
      ALU_SLT: alu_out = {{(WIDTH - 1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALU_NOR: alu_out = ~(bus.a | bus.b);
      default: alu_out = '0;
    endcase
  end

  mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul_seq (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .a       (bus.a),
    .b       (bus.b),
    .product (mul_product),
    .last    (mul_last)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.gin == ALU_MUL) begin
            mul_load = 1'b1;
            state_d  = MUL;
          end else begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            done_d   = 1'b1;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        // Final step retires straight into the result register.
        if (mul_last) begin
          result_d = mul_product;
          zero_d   = (mul_product == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q == MUL);

endmodule
